// File: rtl/divide.sv
// Sequential signed fixed-point divider: result = a/b with FRAC_W fractional bits,
// restoring shift-subtract, one quotient bit per cycle. Define DIVIDE_ROUND_EN for half-up rounding.
module divide #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     en,
  output logic                     fin,
  output logic signed [DATA_W-1:0] result
);

  localparam int MAG_W = DATA_W + 1;
  localparam int REM_W = MAG_W + 1;
  localparam int QW    = DATA_W + FRAC_W;
  localparam int CNT_W = $clog2(QW + 1);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QW);
  localparam logic [QW:0]      POS_LIM   = (QW+1)'((64'd1 << (DATA_W-1)) - 64'd1);
  localparam logic [QW:0]      NEG_LIM   = (QW+1)'(64'd1 << (DATA_W-1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             neg;
  logic [MAG_W-1:0] b_mag;
  logic [REM_W-1:0] rem;
  logic [QW-1:0]    quo;
  logic [CNT_W-1:0] count;

  // Operand magnitudes are one bit wider than the inputs so |-2^(DATA_W-1)| fits.
  logic signed [MAG_W-1:0] a_ext, b_ext;
  logic [MAG_W-1:0]        a_mag, b_mag_in;

  always_comb begin
    a_ext    = {a[DATA_W-1], a};
    b_ext    = {b[DATA_W-1], b};
    a_mag    = a_ext[MAG_W-1] ? MAG_W'(-a_ext) : MAG_W'(a_ext);
    b_mag_in = b_ext[MAG_W-1] ? MAG_W'(-b_ext) : MAG_W'(b_ext);
  end

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  logic [REM_W-1:0] rem_shift, b_wide, rem_next;
  logic             fits;
  logic [QW-1:0]    quo_next;

  always_comb begin
    rem_shift = {rem[REM_W-2:0], quo[QW-1]};
    b_wide    = REM_W'(b_mag);
    fits      = (rem_shift >= b_wide);
    rem_next  = fits ? (rem_shift - b_wide) : rem_shift;
    quo_next  = {quo[QW-2:0], fits};
  end

  // Final magnitude, optional rounding, then sign and saturation.
  logic                    round_up;
  logic [QW:0]             mag_final;
  logic signed [DATA_W-1:0] result_next;

  always_comb begin
`ifdef DIVIDE_ROUND_EN
    round_up = ({rem, 1'b0} >= (REM_W+1)'(b_mag));
`else
    round_up = 1'b0;
`endif
    mag_final = {1'b0, quo} + (QW+1)'(round_up);
    if (!neg) begin
      if (mag_final > POS_LIM)
        result_next = DATA_W'(POS_LIM);
      else
        result_next = DATA_W'(mag_final);
    end else begin
      if (mag_final > NEG_LIM)
        result_next = DATA_W'(NEG_LIM);
      else
        result_next = -DATA_W'(mag_final);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      neg    <= 1'b0;
      b_mag  <= '0;
      rem    <= '0;
      quo    <= '0;
      count  <= '0;
      fin    <= 1'b0;
      result <= '0;
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            neg   <= a[DATA_W-1] ^ b[DATA_W-1];
            b_mag <= b_mag_in;
            rem   <= '0;
            quo   <= QW'({a_mag, {FRAC_W{1'b0}}});
            count <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          // QW iteration cycles, then one finalize cycle that loads result.
          if (count != LAST_ITER) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + CNT_W'(1);
          end else begin
            result <= result_next;
            fin    <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide.sv
// Directed self-checking bench for divide: latency, quotient values, saturation,
// divide-by-zero, back-to-back spacing and mid-operation reset.
module tb_divide;

  logic               i_clk;
  logic               i_rst;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               en;
  logic               fin;
  logic signed [15:0] result;

  int checks = 0;
  int errors = 0;

  divide #(.DATA_W(16), .FRAC_W(14)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .a      (a),
    .b      (b),
    .en     (en),
    .fin    (fin),
    .result (result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start one operation from IDLE, scramble inputs during CALC, check latency,
  // value, single-cycle pulse and hold.
  task automatic run_op(input string tag, input int av, input int bv, input int exp);
    int cycles;
    bit got;
    @(negedge i_clk);
    a  = 16'(av);
    b  = 16'(bv);
    en = 1'b1;
    @(posedge i_clk);
    #1;
    en = 1'b0;
    a  = 16'sh5a5a;
    b  = 16'sh0003;
    cycles = 0;
    got    = 1'b0;
    while (cycles < 60 && !got) begin
      @(posedge i_clk);
      cycles++;
      #1;
      if (fin) got = 1'b1;
    end
    check({tag, "_lat"}, cycles, 31);
    check({tag, "_res"}, int'(result), exp);
    @(posedge i_clk);
    #1;
    check({tag, "_pulse"}, int'(fin), 0);
    check({tag, "_hold"}, int'(result), exp);
  endtask

  initial begin
    int n;
    int stale;
    bit got;

    i_rst = 1'b1;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    #22;
    check("rst_fin", int'(fin), 0);
    check("rst_result", int'(result), 0);
    @(negedge i_clk);
    i_rst = 1'b0;

`ifdef DIVIDE_ROUND_EN
    run_op("vec_029", -5066, 10028, -8277);
    run_op("two_thirds", 2, 3, 10923);
`else
    run_op("vec_029", -5066, 10028, -8276);
    run_op("two_thirds", 2, 3, 10922);
`endif
    run_op("half", 5000, 10000, 8192);
    run_op("neg_one", -10000, 10000, -16384);
    run_op("sat_pos", 30000, 1, 32767);
    run_op("min_neg", -32768, 1, -32768);
    run_op("div0_pos", 100, 0, 32767);
    run_op("div0_neg", -1, 0, -32768);
    run_op("zero_num", 0, 7, 0);
    run_op("third", 1, 3, 5461);
    run_op("neg_third", -1, 3, -5461);
    run_op("both_neg", -1, -2, 8192);
    run_op("edge_pos", 2, 1, 32767);
    run_op("edge_neg", 2, -1, -32768);

    // en held high: completions every 33 cycles.
    @(negedge i_clk);
    a  = 16'sd5000;
    b  = 16'sd10000;
    en = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 80 && !got) begin
      @(posedge i_clk);
      n++;
      #1;
      if (fin) got = 1'b1;
    end
    check("b2b_first", int'(got), 1);
    n = 0;
    got = 1'b0;
    while (n < 80 && !got) begin
      @(posedge i_clk);
      n++;
      #1;
      if (fin) got = 1'b1;
    end
    check("b2b_period", n, 33);
    check("b2b_res", int'(result), 8192);
    @(negedge i_clk);
    en = 1'b0;
    repeat (3) @(posedge i_clk);

    // Reset 10 cycles into CALC aborts with no later pulse.
    @(negedge i_clk);
    a  = -16'sd5066;
    b  = 16'sd10028;
    en = 1'b1;
    @(posedge i_clk);
    #1;
    en = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check("abort_fin", int'(fin), 0);
    check("abort_result", int'(result), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      if (fin) stale++;
    end
    check("no_stale_fin", stale, 0);

    run_op("after_rst", -10000, 10000, -16384);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter FRAC_W, default 14, giving the number of fractional bits in the result.
REQ-003 Port i_clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Port a SHALL be an input, signed DATA_W bits: the dividend (integer).
REQ-006 Port b SHALL be an input, signed DATA_W bits: the divisor (integer).
REQ-007 Port en SHALL be an input, 1 bit: start request, sampled only in IDLE.
REQ-008 Port fin SHALL be an output, 1 bit: one-cycle done pulse.
REQ-009 Port result SHALL be an output, signed DATA_W bits: the quotient a/b in signed fixed point with FRAC_W fractional bits (Q1.14 at defaults).

Function
REQ-010 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-011 In IDLE with en=1 at a rising edge, the block SHALL capture sign(a) XOR sign(b), |a| and |b| into 17-bit magnitudes (so that -32768 is representable), then enter CALC.
REQ-012 In IDLE with en=0, the block SHALL remain in IDLE.
REQ-013 CALC SHALL run a restoring shift-subtract of dividend |a|<<FRAC_W by |b| over DATA_W+FRAC_W cycles (30 at defaults), producing one quotient bit per cycle, MSB first.
REQ-014 After the last iteration the block SHALL enter DONE; fin SHALL be 1 for exactly the single DONE cycle, with result valid in that cycle.
REQ-015 Latency SHALL be: capture edge E0, fin high in the cycle following edge E0+31.
REQ-016 DONE SHALL always return to IDLE at the next edge; with en held at 1, a new operation is therefore captured every 33 cycles.
REQ-017 Default rounding SHALL truncate toward zero: magnitude = floor(|a|*2^FRAC_W / |b|), then negated if the captured sign is 1.
REQ-018 Saturation: a positive result whose magnitude exceeds 2^(DATA_W-1)-1 SHALL output 32767; a negative result whose magnitude exceeds 2^(DATA_W-1) SHALL output -32768.
REQ-019 Divide by zero (b=0) SHALL follow the normal latency and output 32767 if a>=0, else -32768.
REQ-020 a=0 with b nonzero SHALL output 0.
REQ-021 result SHALL be registered, load only on the transition into DONE, and hold its value until the next completion.
REQ-022 Changes on a, b or en during CALC or DONE SHALL be ignored.

Reset
REQ-023 While i_rst=1, the state SHALL be IDLE, fin=0, result=0, and all internal registers 0, regardless of the clock.
REQ-024 A reset asserted mid-operation SHALL abort the operation; no fin pulse SHALL occur for the aborted operation.
REQ-025 After reset deasserts, the first en=1 sampled in IDLE SHALL start a new operation.

Configuration
REQ-026 When macro DIVIDE_ROUND_EN is defined, the quotient magnitude SHALL be rounded half-up: magnitude+1 when 2*final_remainder >= |b|, applied before sign and saturation.
REQ-027 Without DIVIDE_ROUND_EN, the block SHALL truncate per REQ-017.
REQ-028 Latency SHALL be identical with and without DIVIDE_ROUND_EN.

Verification
REQ-029 Reset pulse, then en=1, a=-5066, b=10028 -> fin pulses 31 cycles after the capture edge with result=-8276 (-8277 with DIVIDE_ROUND_EN).
REQ-030 a=5000, b=10000 -> result=8192; a=-10000, b=10000 -> result=-16384.
REQ-031 a=30000, b=1 -> result=32767 (saturated); a=-32768, b=1 -> result=-32768.
REQ-032 b=0 with a=100 -> result=32767; b=0 with a=-1 -> result=-32768; both with normal latency.
REQ-033 en held at 1 -> fin pulses repeat every 33 cycles; i_rst asserted 10 cycles into CALC -> fin=0, result=0, and no stale fin pulse afterwards.
